// File: rtl/mux32_pkg.sv
// Shared constants and types for the 32:1 mux scan controller.
// The index step helper keeps the up/down arithmetic in one place.
package mux32_pkg;

    localparam int WIDTH = 32;
    localparam int SEL_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    typedef logic [SEL_W-1:0] bit_idx_t;

    // The caller guarantees the index is never stepped past the end index,
    // so plain modulo arithmetic is sufficient here.
    function automatic bit_idx_t step_idx(input bit_idx_t idx, input logic up);
        bit_idx_t nxt;
        if (up) begin
            nxt = idx + bit_idx_t'(1);
        end else begin
            nxt = idx - bit_idx_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mux32_scan_ctrl.sv
// Scans a captured word through an external 32:1 mux, one select per bit,
// and streams the sampled bits out over a valid/ready serial interface.
module mux32_scan_ctrl
    import mux32_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic [SEL_W-1:0] first_i,
    input  logic [SEL_W-1:0] last_i,
    input  logic             abort_i,
    output logic [WIDTH-1:0] mux_in_o,
    output logic [SEL_W-1:0] mux_sel_o,
    input  logic             mux_out_i,
    output logic             ser_bit_o,
    output logic             ser_valid_o,
    input  logic             ser_ready_i,
    output logic             ser_last_o,
    output logic             busy_o,
    output logic             done_o
);

    scan_state_t state;
    bit_idx_t    end_idx;
    logic        dir_up;

    // Scan FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mux_in_o    <= '0;
            mux_sel_o   <= '0;
            end_idx     <= '0;
            dir_up      <= 1'b0;
            ser_bit_o   <= 1'b0;
            ser_valid_o <= 1'b0;
            ser_last_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            // Abort wins over a same-cycle handshake and suppresses done.
            if (abort_i && (state != IDLE)) begin
                state       <= IDLE;
                ser_valid_o <= 1'b0;
                ser_last_o  <= 1'b0;
                busy_o      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            mux_in_o  <= word_i;
                            mux_sel_o <= first_i;
                            end_idx   <= last_i;
                            dir_up    <= (first_i <= last_i);
                            busy_o    <= 1'b1;
                            state     <= FETCH;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    FETCH: begin
                        ser_bit_o   <= mux_out_i;
                        ser_last_o  <= (mux_sel_o == end_idx);
                        ser_valid_o <= 1'b1;
                        state       <= SEND;
                    end
                    SEND: begin
                        if (ser_ready_i) begin
                            ser_valid_o <= 1'b0;
                            ser_last_o  <= 1'b0;
                            if (ser_last_o) begin
                                done_o <= 1'b1;
                                state  <= DONE;
                            end else begin
                                mux_sel_o <= step_idx(mux_sel_o, dir_up);
                                state     <= FETCH;
                            end
                        end else begin
                            state <= SEND;
                        end
                    end
                    DONE: begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                    default: begin
                        ser_valid_o <= 1'b0;
                        ser_last_o  <= 1'b0;
                        busy_o      <= 1'b0;
                        state       <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mux32_scan_ctrl.sv
// Scoreboard bench for mux32_scan_ctrl with a behavioural 32:1 mux beside it.
module tb_mux32_scan_ctrl;
    import mux32_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] word = '0;
    logic [SEL_W-1:0] first = '0;
    logic [SEL_W-1:0] last = '0;
    logic             abort = 1'b0;
    logic             ser_ready = 1'b0;
    logic [WIDTH-1:0] mux_in;
    logic [SEL_W-1:0] mux_sel;
    logic             mux_out;
    logic             ser_bit, ser_valid, ser_last, busy, done;

    mux32_scan_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .word_i(word),
        .first_i(first), .last_i(last), .abort_i(abort),
        .mux_in_o(mux_in), .mux_sel_o(mux_sel), .mux_out_i(mux_out),
        .ser_bit_o(ser_bit), .ser_valid_o(ser_valid), .ser_ready_i(ser_ready),
        .ser_last_o(ser_last), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;
    assign mux_out = mux_in[mux_sel];

    typedef struct {
        logic       b;
        logic       l;
        logic [4:0] idx;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total = 0;
    int   handshakes = 0;
    int   dones = 0;
    int   stall_seen = 0;
    int   stall_left = 0;
    int   ready_mode = 0;
    bit   done_armed = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference: the list of (bit, last flag, index) the scan must emit.
    function automatic void model(input logic [31:0] w, input int f, input int l);
        int n;
        int step;
        exp_t e;
        n    = (f <= l) ? (l - f + 1) : (f - l + 1);
        step = (f <= l) ? 1 : -1;
        for (int k = 0; k < n; k++) begin
            int i;
            i     = f + k * step;
            e.b   = w[i];
            e.l   = (k == n - 1);
            e.idx = 5'(i);
            q.push_back(e);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Downstream ready: constant, random, or a 5-cycle stall on bit 3.
    initial begin
        forever begin
            tick();
            case (ready_mode)
                0: ser_ready = 1'b1;
                1: ser_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (ser_valid && handshakes == 3 && stall_left > 0) begin
                        ser_ready = 1'b0;
                        stall_left--;
                    end else begin
                        ser_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks holds/aborts.
    initial begin
        logic p_valid, p_ready, p_abort, p_busy, p_bit, p_last;
        logic [4:0] p_sel;
        exp_t e;
        p_valid = 1'b0; p_ready = 1'b0; p_abort = 1'b0; p_busy = 1'b0;
        p_bit = 1'b0; p_last = 1'b0; p_sel = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_valid = 1'b0; p_abort = 1'b0; p_busy = 1'b0;
            end else begin
                if (p_valid && !p_ready && !p_abort) begin
                    stall_seen++;
                    check("stall_valid", ser_valid, 1'b1);
                    check("stall_bit", ser_bit, p_bit);
                    check("stall_last", ser_last, p_last);
                    check("stall_sel", mux_sel, p_sel);
                end
                if (p_abort && p_busy) begin
                    check("abort_valid", ser_valid, 1'b0);
                    check("abort_last", ser_last, 1'b0);
                    check("abort_busy", busy, 1'b0);
                    check("abort_done", done, 1'b0);
                end
                if (done) begin
                    dones++;
                    check("done_expected", done_armed, 1'b1);
                    check("done_queue_empty", q.size(), 0);
                    done_armed = 1'b0;
                end
                if (ser_valid && ser_ready && !abort) begin
                    handshakes++;
                    if (q.size() == 0) begin
                        check("unexpected_bit", 1'b1, 1'b0);
                    end else begin
                        e = q.pop_front();
                        check("ser_bit", ser_bit, e.b);
                        check("ser_last", ser_last, e.l);
                        check("mux_sel", mux_sel, e.idx);
                        if (e.l) done_armed = 1'b1;
                    end
                end
                p_valid = ser_valid; p_ready = ser_ready; p_abort = abort;
                p_busy = busy; p_bit = ser_bit; p_last = ser_last; p_sel = mux_sel;
            end
        end
    end

    task automatic drive_start(input logic [31:0] w, input int f, input int l, input logic ab);
        start = 1'b1; word = w; first = 5'(f); last = 5'(l); abort = ab;
        handshakes = 0;
        model(w, f, l);
        tick();
        start = 1'b0; abort = 1'b0; word = $urandom;
        first = 5'($urandom_range(0, 31)); last = 5'($urandom_range(0, 31));
    endtask

    // One complete scan; cycles counted including the cycle start is driven.
    task automatic run_scan(input logic [31:0] w, input int f, input int l,
                            input bit chk_lat, input logic ab);
        int c;
        int fv;
        int n;
        n  = (f <= l) ? (l - f + 1) : (f - l + 1);
        fv = 0;
        drive_start(w, f, l, ab);
        c = 1;
        check("busy_after_start", busy, 1'b1);
        check("mux_in_captured", mux_in, w);
        while (!done && c < 2000) begin
            tick();
            c++;
            if (ser_valid && fv == 0) fv = c;
        end
        check("done_seen", done, 1'b1);
        if (chk_lat) begin
            check("first_valid_latency", fv, 2);
            check("done_latency", c, 2 * n + 1);
        end
        tick();
        check("idle_after_done", busy, 1'b0);
        check("mux_in_kept", mux_in, w);
    endtask

    initial begin
        bit second_sent;
        int c;
        int d0;
        #2;
        check("rst_mux_in", mux_in, 32'h0);
        check("rst_sel", mux_sel, 5'd0);
        check("rst_valid_bit_last", {ser_valid, ser_bit, ser_last}, 3'b000);
        check("rst_busy_done", {busy, done}, 2'b00);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        ready_mode = 0;
        run_scan(32'hAAAAAAAA, 0, 31, 1'b1, 1'b0);
        run_scan(32'h80000001, 31, 0, 1'b1, 1'b0);
        run_scan(32'h00000080, 7, 7, 1'b1, 1'b0);
        // Start together with abort while idle starts normally.
        run_scan(32'h0000F00F, 3, 12, 1'b1, 1'b1);

        ready_mode = 2; stall_left = 5; stall_seen = 0;
        run_scan($urandom, 0, 15, 1'b0, 1'b0);
        check("stall_cycles", stall_seen, 5);

        // Abort at bit 10 with an ignored second start in between.
        ready_mode = 0;
        drive_start($urandom, 0, 31, 1'b0);
        second_sent = 1'b0;
        c = 0;
        while (!(handshakes == 10 && ser_valid) && c < 200) begin
            if (handshakes == 4 && !second_sent) begin
                start = 1'b1; word = 32'hFFFFFFFF; first = 5'd20; last = 5'd25;
                second_sent = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            c++;
        end
        start = 1'b0;
        check("abort_reached_bit10", handshakes, 10);
        d0 = dones;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        q.delete();
        done_armed = 1'b0;
        check("abort_idle_busy", busy, 1'b0);
        check("abort_idle_valid", ser_valid, 1'b0);
        repeat (5) tick();
        check("abort_no_done", dones, d0);

        // Asynchronous reset mid-scan.
        drive_start($urandom, 2, 29, 1'b0);
        repeat (6) tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_mux_in", mux_in, 32'h0);
        check("mrst_sel", mux_sel, 5'd0);
        check("mrst_valid_bit_last", {ser_valid, ser_bit, ser_last}, 3'b000);
        check("mrst_busy_done", {busy, done}, 2'b00);
        q.delete();
        done_armed = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run_scan(32'h12345678, 31, 16, 1'b1, 1'b0);

        ready_mode = 1;
        for (int t = 0; t < 10; t++) begin
            run_scan($urandom, $urandom_range(0, 31), $urandom_range(0, 31), 1'b0, 1'b0);
        end

        check("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
